// File: rtl/prioritized_weighted_arbiter_pkg.sv
// Shared types and sizing helpers for the prioritized weighted arbiter.
// Build option: PRIORITIZED_WEIGHTED_ARBITER_PREEMPT_EN (see the top module).
package prioritized_weighted_arbiter_pkg;

  // IDLE: no grant outstanding. GRANT: a tenure is in progress.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int index_width(input int request_width);
    return (request_width > 1) ? $clog2(request_width) : 1;
  endfunction

  // Width of one arbitration key: {request, priority, above_ptr, index rank}.
  function automatic int compare_width(input int priority_width, input int idx_width);
    return 1 + priority_width + 1 + idx_width;
  endfunction

endpackage

// File: rtl/prioritized_weighted_arbiter_max_finder.sv
// Returns the position of the largest of NUM packed unsigned values.
// Keys are expected to be unique; on a tie the lowest position wins.
module max_finder #(
  parameter int NUM         = 4,
  parameter int WIDTH       = 8,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [NUM*WIDTH-1:0]  values,
  output logic [INDEX_WIDTH-1:0] max_index
);

  logic [WIDTH-1:0] max_value;

  // Linear scan keeping the running maximum and its position.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    max_value = values[WIDTH-1:0];
    max_index = '0;
    for (int i = 1; i < NUM; i++) begin
      if (values[i*WIDTH +: WIDTH] > max_value) begin
        max_value = values[i*WIDTH +: WIDTH];
        max_index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/prioritized_weighted_arbiter.sv
// Prioritized weighted arbiter: strict priority between levels, round-robin
// within a level, and a winner keeps the grant for up to WEIGHT acked beats.
// Build option: PRIORITIZED_WEIGHTED_ARBITER_PREEMPT_EN lets a strictly
// higher-priority request end the current tenure at the next acked beat.
module prioritized_weighted_arbiter
  import prioritized_weighted_arbiter_pkg::*;
#(
  parameter int REQUEST_WIDTH  = 4,
  parameter int PRIORITY_WIDTH = 2,
  parameter int WEIGHT_WIDTH   = 4,
  localparam int INDEX_WIDTH   = index_width(REQUEST_WIDTH)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [REQUEST_WIDTH*PRIORITY_WIDTH-1:0] i_priority,
  input  logic [REQUEST_WIDTH*WEIGHT_WIDTH-1:0]   i_weight,
  input  logic [REQUEST_WIDTH-1:0]               i_request,
  input  logic                                   i_ack,
  output logic [REQUEST_WIDTH-1:0]               o_grant,
  output logic [INDEX_WIDTH-1:0]                 o_grant_index,
  output logic                                   o_grant_valid
);

  localparam int COMPARE_WIDTH = compare_width(PRIORITY_WIDTH, INDEX_WIDTH);

  // Field order sets comparison significance. index holds the inverted
  // requester number so the lowest index wins the final tie-break.
  typedef struct packed {
    logic                      request;
    logic [PRIORITY_WIDTH-1:0] prio;
    logic                      above_ptr;
    logic [INDEX_WIDTH-1:0]    index;
  } compare_t;

  state_e                                 state;
  logic [INDEX_WIDTH-1:0]                 rr_ptr;
  logic [WEIGHT_WIDTH-1:0]                beat_count;
  logic [REQUEST_WIDTH*COMPARE_WIDTH-1:0] compare_values;
  compare_t                               key;
  logic [INDEX_WIDTH-1:0]                 winner_index;
  logic [REQUEST_WIDTH-1:0]               winner_grant;
  logic [WEIGHT_WIDTH-1:0]                winner_weight;
  logic [WEIGHT_WIDTH-1:0]                winner_beats;
  logic [PRIORITY_WIDTH-1:0]              winner_prio;
  logic                                   any_request;
  logic                                   holder_request;
  logic                                   preempt;
  logic                                   tenure_end;
  logic                                   load_winner;

  // Build one arbitration key per requester.
  always_comb begin
    compare_values = '0;
    key            = '0;
    for (int i = 0; i < REQUEST_WIDTH; i++) begin
      key.request   = i_request[i];
      key.prio      = i_priority[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
      key.above_ptr = (INDEX_WIDTH'(i) > rr_ptr);
      key.index     = ~INDEX_WIDTH'(i);
      compare_values[i*COMPARE_WIDTH +: COMPARE_WIDTH] = key;
    end
  end

  max_finder #(
    .NUM         (REQUEST_WIDTH),
    .WIDTH       (COMPARE_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_max_finder (
    .values    (compare_values),
    .max_index (winner_index)
  );

  // Decode the winner into a one-hot grant and pick its weight and priority.
  always_comb begin
    winner_grant  = '0;
    winner_weight = '0;
    winner_prio   = '0;
    for (int i = 0; i < REQUEST_WIDTH; i++) begin
      if (winner_index == INDEX_WIDTH'(i)) begin
        winner_grant[i] = 1'b1;
        winner_weight   = i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        winner_prio     = i_priority[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
      end
    end
  end

  assign winner_beats   = (winner_weight == '0) ? WEIGHT_WIDTH'(1) : winner_weight;
  assign any_request    = |i_request;
  assign holder_request = |(i_request & o_grant);

`ifdef PRIORITIZED_WEIGHTED_ARBITER_PREEMPT_EN
  logic [PRIORITY_WIDTH-1:0] holder_prio;

  // Flag any other pending requester ranked strictly above the holder.
  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < REQUEST_WIDTH; i++) begin
      if (i_request[i] && !o_grant[i] &&
          (i_priority[i*PRIORITY_WIDTH +: PRIORITY_WIDTH] > holder_prio)) begin
        preempt = 1'b1;
      end
    end
  end

  // Latch the winner's priority at the start of each tenure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      holder_prio <= '0;
    end else if (load_winner) begin
      holder_prio <= winner_prio;
    end
  end
`else
  logic [PRIORITY_WIDTH-1:0] unused_winner_prio;

  assign preempt            = 1'b0;
  assign unused_winner_prio = winner_prio;
`endif

  // Tenure ends when the holder withdraws, on its last beat, or when preempted.
  assign tenure_end  = (state == GRANT) &&
                       (!holder_request || (i_ack && (beat_count == WEIGHT_WIDTH'(1))) ||
                        (i_ack && preempt));
  assign load_winner = any_request && ((state == IDLE) || tenure_end);

  // Grant state, round-robin pointer and beat counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_grant       <= '0;
      o_grant_index <= '0;
      rr_ptr        <= '0;
      beat_count    <= '0;
    end else if (load_winner) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state         <= GRANT;
      o_grant       <= winner_grant;
      o_grant_index <= winner_index;
      rr_ptr        <= winner_index;
      beat_count    <= winner_beats;
    end else if (tenure_end) begin
      state         <= IDLE;
      o_grant       <= '0;
      o_grant_index <= '0;
      beat_count    <= '0;
    end else if ((state == GRANT) && i_ack) begin
      beat_count    <= beat_count - WEIGHT_WIDTH'(1);
    end
  end

  assign o_grant_valid = |o_grant;

endmodule

// File: tb/tb_prioritized_weighted_arbiter.sv
// Directed self-checking bench for prioritized_weighted_arbiter (4 requesters).
// Honours PRIORITIZED_WEIGHTED_ARBITER_PREEMPT_EN for the preemption scenario.
module tb_prioritized_weighted_arbiter;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_priority;
  logic [15:0] i_weight;
  logic [3:0] i_request;
  logic       i_ack;
  logic [3:0] o_grant;
  logic [1:0] o_grant_index;
  logic       o_grant_valid;

  int vectors;
  int miscompares;

  prioritized_weighted_arbiter #(
    .REQUEST_WIDTH  (4),
    .PRIORITY_WIDTH (2),
    .WEIGHT_WIDTH   (4)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_priority    (i_priority),
    .i_weight      (i_weight),
    .i_request     (i_request),
    .i_ack         (i_ack),
    .o_grant       (o_grant),
    .o_grant_index (o_grant_index),
    .o_grant_valid (o_grant_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n    = 1'b0;
    i_priority = '0;
    i_weight   = {4'd1, 4'd1, 4'd1, 4'd1};
    i_request  = '0;
    i_ack      = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n    = 1'b0;
    i_priority = '0;
    i_weight   = '0;
    i_request  = 4'b1111;
    i_ack      = 1'b1;
    #3;
    vectors++;
    if (o_grant !== 4'b0000) begin
      miscompares++; $display("FAIL reset_grant got %b expected 0000", o_grant);
    end
    vectors++;
    if (o_grant_index !== 2'd0) begin
      miscompares++; $display("FAIL reset_index got %0d expected 0", o_grant_index);
    end
    vectors++;
    if (o_grant_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got %b expected 0", o_grant_valid);
    end
    tick();
  endtask

  // Equal priority, weight 1, ack every cycle: rotation starts above index 0.
  task automatic test_round_robin();
    int exp_idx [5] = '{1, 2, 3, 0, 1};
    apply_reset();
    i_request = 4'b1111;
    i_ack     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (o_grant !== (4'b0001 << exp_idx[k]) || o_grant_index !== 2'(exp_idx[k]) || o_grant_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL round_robin[%0d] got grant=%b idx=%0d valid=%b expected idx=%0d", k, o_grant, o_grant_index, o_grant_valid, exp_idx[k]);
      end
    end
  endtask

  task automatic test_strict_priority();
    apply_reset();
    i_priority = {2'd3, 2'd1, 2'd1, 2'd1};
    i_request  = 4'b1111;
    i_ack      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (o_grant !== 4'b1000 || o_grant_index !== 2'd3) begin
        miscompares++;
        $display("FAIL strict_priority[%0d] got grant=%b idx=%0d expected 1000 idx=3", k, o_grant, o_grant_index);
      end
    end
  endtask

  // Weights {w3,w2,w1,w0} = {1,0,3,2}; w2=0 behaves as one beat.
  task automatic test_weights();
    int exp_idx [8] = '{1, 1, 1, 2, 3, 0, 0, 1};
    apply_reset();
    i_weight  = {4'd1, 4'd0, 4'd3, 4'd2};
    i_request = 4'b1111;
    i_ack     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if (o_grant_index !== 2'(exp_idx[k]) || o_grant !== (4'b0001 << exp_idx[k])) begin
        miscompares++;
        $display("FAIL weights[%0d] got grant=%b idx=%0d expected idx=%0d", k, o_grant, o_grant_index, exp_idx[k]);
      end
    end
  endtask

  // Acks while idle are ignored; weight 2 then holds for two beats.
  task automatic test_idle_ack();
    apply_reset();
    i_weight = {4'd1, 4'd1, 4'd1, 4'd2};
    i_ack    = 1'b1;
    tick();
    tick();
    vectors++;
    if (o_grant_valid !== 1'b0) begin
      miscompares++; $display("FAIL idle_ack got valid=%b expected 0", o_grant_valid);
    end
    i_ack     = 1'b0;
    i_request = 4'b0001;
    tick();
    vectors++;
    if (o_grant !== 4'b0001) begin
      miscompares++; $display("FAIL idle_first_grant got %b expected 0001", o_grant);
    end
    i_request = 4'b0011;
    i_ack     = 1'b1;
    tick();
    vectors++;
    if (o_grant !== 4'b0001) begin
      miscompares++; $display("FAIL idle_beat1 got %b expected 0001", o_grant);
    end
    tick();
    vectors++;
    if (o_grant !== 4'b0010) begin
      miscompares++; $display("FAIL idle_beat2 got %b expected 0010", o_grant);
    end
    i_request = 4'b0000;
    tick();
    vectors++;
    if (o_grant !== 4'b0000 || o_grant_valid !== 1'b0) begin
      miscompares++; $display("FAIL release_to_idle got grant=%b valid=%b expected 0000/0", o_grant, o_grant_valid);
    end
  endtask

  // Holder withdraws mid-tenure; grant moves immediately to the pending requester.
  task automatic test_drop_request();
    apply_reset();
    i_weight  = {4'd1, 4'd3, 4'd5, 4'd1};
    i_request = 4'b0010;
    tick();
    i_request = 4'b0110;
    i_ack     = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (o_grant !== 4'b0010) begin
        miscompares++; $display("FAIL drop_hold[%0d] got %b expected 0010", k, o_grant);
      end
    end
    i_request = 4'b0100;
    tick();
    vectors++;
    if (o_grant !== 4'b0100 || o_grant_index !== 2'd2) begin
      miscompares++; $display("FAIL drop_move got grant=%b idx=%0d expected 0100 idx=2", o_grant, o_grant_index);
    end
    // Req1 returns; req2 still owns its 3-beat tenure.
    i_request = 4'b0110;
    tick();
    tick();
    vectors++;
    if (o_grant !== 4'b0100) begin
      miscompares++; $display("FAIL drop_tenure got %b expected 0100", o_grant);
    end
    tick();
    vectors++;
    if (o_grant !== 4'b0010) begin
      miscompares++; $display("FAIL drop_after got %b expected 0010", o_grant);
    end
  endtask

  // All-ones weight: exactly 15 beats before the grant moves.
  task automatic test_max_weight();
    apply_reset();
    i_weight  = {4'd1, 4'd1, 4'd15, 4'd1};
    i_request = 4'b0010;
    tick();
    i_request = 4'b0110;
    i_ack     = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    vectors++;
    if (o_grant !== 4'b0010) begin
      miscompares++; $display("FAIL max_weight_hold got %b expected 0010", o_grant);
    end
    tick();
    vectors++;
    if (o_grant !== 4'b0100) begin
      miscompares++; $display("FAIL max_weight_release got %b expected 0100", o_grant);
    end
  endtask

  // Asynchronous reset mid-tenure, then rr pointer restarts at 0.
  task automatic test_reset_mid_tenure();
    apply_reset();
    i_weight  = {4'd1, 4'd1, 4'd5, 4'd1};
    i_request = 4'b0010;
    tick();
    i_ack = 1'b1;
    tick();
    tick();
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_grant !== 4'b0000 || o_grant_valid !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got grant=%b valid=%b expected 0000/0", o_grant, o_grant_valid);
    end
    i_ack     = 1'b0;
    i_request = 4'b0101;
    tick();
    i_rst_n = 1'b1;
    tick();
    vectors++;
    if (o_grant !== 4'b0100 || o_grant_index !== 2'd2) begin
      miscompares++; $display("FAIL post_reset_grant got grant=%b idx=%0d expected 0100 idx=2", o_grant, o_grant_index);
    end
  endtask

  // Higher-priority arrival during a weight-8 tenure of req0.
  task automatic test_preempt();
    apply_reset();
    i_weight  = {4'd1, 4'd1, 4'd1, 4'd8};
    i_request = 4'b0001;
    tick();
    i_ack = 1'b1;
    tick();
    i_priority = {2'd2, 2'd0, 2'd0, 2'd0};
    i_request  = 4'b1001;
    i_ack      = 1'b0;
    tick();
    vectors++;
    if (o_grant !== 4'b0001) begin
      miscompares++; $display("FAIL preempt_wait got %b expected 0001", o_grant);
    end
    i_ack = 1'b1;
`ifdef PRIORITIZED_WEIGHTED_ARBITER_PREEMPT_EN
    tick();
    vectors++;
    if (o_grant !== 4'b1000 || o_grant_index !== 2'd3) begin
      miscompares++; $display("FAIL preempt_take got grant=%b idx=%0d expected 1000 idx=3", o_grant, o_grant_index);
    end
`else
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (o_grant !== 4'b0001) begin
        miscompares++; $display("FAIL no_preempt_hold[%0d] got %b expected 0001", k, o_grant);
      end
    end
    tick();
    vectors++;
    if (o_grant !== 4'b1000) begin
      miscompares++; $display("FAIL no_preempt_release got %b expected 1000", o_grant);
    end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_strict_priority();
    test_weights();
    test_idle_ack();
    test_drop_request();
    test_max_weight();
    test_reset_mid_tenure();
    test_preempt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
